// File: rtl/traffic_phase_arbiter.sv
// Four-way intersection phase scheduler: latched sensor demand, round-robin green,
// yellow + all-red clearance on every change, and emergency pre-emption.
module traffic_phase_arbiter #(
    parameter int GREEN_MIN = 8,
    parameter int GREEN_MAX = 20,
    parameter int YELLOW    = 3,
    parameter int ALLRED    = 1,
    parameter int CNT_W     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       emerg_valid,
    input  logic [1:0] emerg_road,
    output logic [2:0] A,
    output logic [2:0] B,
    output logic [2:0] C,
    output logic [2:0] D,
    output logic [1:0] cur_road,
    output logic       green_valid
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GREEN,
        S_YELLOW,
        S_ALL_RED
    } state_t;

    localparam logic [CNT_W-1:0] GMIN_LAST = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GMAX_LAST = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(YELLOW - 1);
    localparam logic [CNT_W-1:0] AR_LAST   = CNT_W'(ALLRED - 1);

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    state_t           state, state_next;
    logic [CNT_W-1:0] timer, timer_next;
    logic [1:0]       road_next;
    logic [3:0]       pend, pend_next;
    logic [1:0]       rr_ptr, rr_next;
    logic [3:0]       dem, other;
    logic [1:0]       scan_ptr;
    logic [2:0]       arb;
    logic             found;
    logic [1:0]       winner;
    logic [2:0]       lamp_next [4];

    // Returns {hit, index} of the first set bit scanning from ptr upward, modulo 4.
    function automatic logic [2:0] rr_pick(input logic [3:0] d, input logic [1:0] ptr);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (d[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    assign dem   = pend | req;
    assign other = dem & ~(4'b0001 << cur_road);

    // Leaving all-red, the scan starts just past the road that was last served.
    assign scan_ptr = (state == S_ALL_RED) ? cur_road + 2'd1 : rr_ptr;
    assign arb      = rr_pick(dem, scan_ptr);
    assign found    = emerg_valid | arb[2];
    assign winner   = emerg_valid ? emerg_road : arb[1:0];

    always_comb begin
        state_next = state;
        timer_next = timer;
        road_next  = cur_road;
        rr_next    = rr_ptr;
        case (state)
            S_IDLE: begin
                if (found) begin
                    state_next = S_GREEN;
                    road_next  = winner;
                    timer_next = '0;
                end
            end
            S_GREEN: begin
                timer_next = (timer == GMAX_LAST) ? timer : timer + 1'b1;
                if (emerg_valid) begin
                    if (emerg_road != cur_road) begin
                        state_next = S_YELLOW;
                        timer_next = '0;
                    end
                end else if ((timer >= GMIN_LAST) && (other != 4'b0000) &&
                             (!req[cur_road] || (timer == GMAX_LAST))) begin
                    state_next = S_YELLOW;
                    timer_next = '0;
                end
            end
            S_YELLOW: begin
                if (timer == YEL_LAST) begin
                    state_next = S_ALL_RED;
                    timer_next = '0;
                end else begin
                    timer_next = timer + 1'b1;
                end
            end
            S_ALL_RED: begin
                if (timer == AR_LAST) begin
                    rr_next    = cur_road + 2'd1;
                    timer_next = '0;
                    if (found) begin
                        state_next = S_GREEN;
                        road_next  = winner;
                    end else begin
                        state_next = S_IDLE;
                    end
                end else begin
                    timer_next = timer + 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
                timer_next = '0;
            end
        endcase
    end

    // A road's pending bit is held clear for every cycle it will be green; clear beats set.
    always_comb begin
        pend_next = pend | req;
        if (state_next == S_GREEN) begin
            pend_next = pend_next & ~(4'b0001 << road_next);
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            lamp_next[i] = LAMP_RED;
            if (road_next == 2'(i)) begin
                if (state_next == S_GREEN) begin
                    lamp_next[i] = LAMP_GREEN;
                end else if (state_next == S_YELLOW) begin
                    lamp_next[i] = LAMP_YELLOW;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            timer       <= '0;
            cur_road    <= 2'd0;
            pend        <= 4'b0000;
            rr_ptr      <= 2'd0;
            A           <= LAMP_RED;
            B           <= LAMP_RED;
            C           <= LAMP_RED;
            D           <= LAMP_RED;
            green_valid <= 1'b0;
        end else begin
            state       <= state_next;
            timer       <= timer_next;
            cur_road    <= road_next;
            pend        <= pend_next;
            rr_ptr      <= rr_next;
            A           <= lamp_next[0];
            B           <= lamp_next[1];
            C           <= lamp_next[2];
            D           <= lamp_next[3];
            green_valid <= (state_next == S_GREEN);
        end
    end

endmodule

// File: tb/tb_traffic_phase_arbiter.sv
// Bench for traffic_phase_arbiter: directed scenarios plus random traffic, all checked
// every cycle against a countdown-based model of the phase rules.
module tb_traffic_phase_arbiter;

    localparam int G_MIN = 8;
    localparam int G_MAX = 20;
    localparam int Y_LEN = 3;
    localparam int R_LEN = 1;

    localparam int P_IDLE   = 0;
    localparam int P_GREEN  = 1;
    localparam int P_YELLOW = 2;
    localparam int P_RED    = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       emerg_valid;
    logic [1:0] emerg_road;
    logic [2:0] A, B, C, D;
    logic [1:0] cur_road;
    logic       green_valid;

    int total = 0;
    int bad   = 0;

    int         m_phase, m_road, m_age, m_left, m_ptr;
    logic [3:0] m_pend;
    int         cnt_a_green, cnt_a_yellow, cnt_b_green;

    always #5 clk = ~clk;

    traffic_phase_arbiter #(
        .GREEN_MIN(G_MIN), .GREEN_MAX(G_MAX), .YELLOW(Y_LEN), .ALLRED(R_LEN), .CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .emerg_valid(emerg_valid), .emerg_road(emerg_road),
        .A(A), .B(B), .C(C), .D(D), .cur_road(cur_road), .green_valid(green_valid)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s t=%0t got=%0h want=%0h", tag, $time, obs, exp);
        end
    endtask

    function automatic int pickRoad(input logic [3:0] d, input int ptr, input logic ev, input logic [1:0] er);
        if (ev) return int'(er);
        for (int k = 0; k < 4; k++) begin
            if (d[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    // One clock of the intersection rules, using the inputs present at the edge.
    task automatic modelStep();
        logic [3:0] dem, oth;
        int         t, w;
        logic       leave;
        if (rst) begin
            m_phase = P_IDLE; m_road = 0; m_age = 0; m_left = 0; m_ptr = 0; m_pend = 4'b0000;
            return;
        end
        dem = m_pend | req;
        case (m_phase)
            P_IDLE: begin
                w = pickRoad(dem, m_ptr, emerg_valid, emerg_road);
                if (w >= 0) begin m_phase = P_GREEN; m_road = w; m_age = 0; end
            end
            P_GREEN: begin
                t = (m_age < G_MAX - 1) ? m_age : G_MAX - 1;
                oth = dem;
                oth[m_road] = 1'b0;
                if (emerg_valid) leave = (int'(emerg_road) != m_road);
                else leave = (t >= G_MIN - 1) && (oth != 0) && (!req[m_road] || t == G_MAX - 1);
                if (leave) begin m_phase = P_YELLOW; m_left = Y_LEN; end
                else m_age++;
            end
            P_YELLOW: begin
                m_left--;
                if (m_left == 0) begin m_phase = P_RED; m_left = R_LEN; end
            end
            default: begin
                m_left--;
                if (m_left == 0) begin
                    m_ptr = (m_road + 1) % 4;
                    w = pickRoad(dem, m_ptr, emerg_valid, emerg_road);
                    if (w >= 0) begin m_phase = P_GREEN; m_road = w; m_age = 0; end
                    else m_phase = P_IDLE;
                end
            end
        endcase
        m_pend = m_pend | req;
        if (m_phase == P_GREEN) m_pend[m_road] = 1'b0;
    endtask

    function automatic logic [2:0] expLamp(input int r);
        if (m_road == r && m_phase == P_GREEN)  return 3'b001;
        if (m_road == r && m_phase == P_YELLOW) return 3'b010;
        return 3'b100;
    endfunction

    task automatic tick();
        @(posedge clk);
        modelStep();
        @(negedge clk);
        checkOutput("lampA", 32'(A), 32'(expLamp(0)));
        checkOutput("lampB", 32'(B), 32'(expLamp(1)));
        checkOutput("lampC", 32'(C), 32'(expLamp(2)));
        checkOutput("lampD", 32'(D), 32'(expLamp(3)));
        checkOutput("green_valid", 32'(green_valid), 32'(m_phase == P_GREEN));
        if (m_phase == P_GREEN || m_phase == P_YELLOW)
            checkOutput("cur_road", 32'(cur_road), 32'(m_road));
        if (A == 3'b001) cnt_a_green++;
        if (A == 3'b010) cnt_a_yellow++;
        if (B == 3'b001) cnt_b_green++;
    endtask

    task automatic applyStimulus(input logic r, input logic [3:0] q, input logic ev,
                                 input logic [1:0] er, input int n);
        rst = r; req = q; emerg_valid = ev; emerg_road = er;
        repeat (n) tick();
    endtask

    task automatic clearCounts();
        cnt_a_green = 0; cnt_a_yellow = 0; cnt_b_green = 0;
    endtask

    initial begin
        logic       ev;
        logic [1:0] er;
        logic [3:0] q;
        int         guard;
        m_phase = P_IDLE; m_road = 0; m_age = 0; m_left = 0; m_ptr = 0; m_pend = 4'b0000;
        clearCounts();

        // Reset, then a single A request resting green for a long time.
        applyStimulus(1'b1, 4'b0000, 1'b0, 2'd0, 2);
        checkOutput("rst_lampA", 32'(A), 32'(3'b100));
        applyStimulus(1'b0, 4'b0001, 1'b0, 2'd0, 1);
        checkOutput("single_A_green", 32'(A), 32'(3'b001));
        applyStimulus(1'b0, 4'b0000, 1'b0, 2'd0, 60);
        checkOutput("A_rests", 32'(A), 32'(3'b001));

        // Handover A -> B with B pulsed early in A's green.
        applyStimulus(1'b1, 4'b0000, 1'b0, 2'd0, 2);
        clearCounts();
        applyStimulus(1'b0, 4'b0001, 1'b0, 2'd0, 1);
        applyStimulus(1'b0, 4'b0000, 1'b0, 2'd0, 1);
        applyStimulus(1'b0, 4'b0010, 1'b0, 2'd0, 1);
        applyStimulus(1'b0, 4'b0000, 1'b0, 2'd0, 25);
        checkOutput("handover_green_len", 32'(cnt_a_green), 32'd8);
        checkOutput("handover_yellow_len", 32'(cnt_a_yellow), 32'd3);
        checkOutput("handover_B_green", 32'(B), 32'(3'b001));

        // All roads requesting: each green runs to the maximum.
        applyStimulus(1'b1, 4'b1111, 1'b0, 2'd0, 2);
        clearCounts();
        applyStimulus(1'b0, 4'b1111, 1'b0, 2'd0, 90);
        checkOutput("rr_A_len", 32'(cnt_a_green), 32'd20);
        checkOutput("rr_B_len", 32'(cnt_b_green), 32'd20);
        applyStimulus(1'b0, 4'b1111, 1'b0, 2'd0, 10);

        // Emergency pre-emption to D from A's first green cycle.
        applyStimulus(1'b1, 4'b0000, 1'b0, 2'd0, 2);
        applyStimulus(1'b0, 4'b0001, 1'b0, 2'd0, 1);
        applyStimulus(1'b0, 4'b0111, 1'b1, 2'd3, 1);
        checkOutput("emerg_A_yellow", 32'(A), 32'(3'b010));
        applyStimulus(1'b0, 4'b0111, 1'b1, 2'd3, 40);
        checkOutput("emerg_D_hold", 32'(D), 32'(3'b001));
        applyStimulus(1'b0, 4'b0111, 1'b0, 2'd3, 30);

        // Reset while B is yellow, then a C request.
        applyStimulus(1'b1, 4'b0000, 1'b0, 2'd0, 2);
        applyStimulus(1'b0, 4'b0010, 1'b0, 2'd0, 1);
        rst = 1'b0; req = 4'b0001; emerg_valid = 1'b0;
        guard = 0;
        while (!(m_phase == P_YELLOW && m_road == 1) && guard < 50) begin
            tick();
            guard++;
        end
        checkOutput("reach_B_yellow", 32'(B), 32'(3'b010));
        applyStimulus(1'b1, 4'b0000, 1'b0, 2'd0, 1);
        checkOutput("rst_mid_yellow_B", 32'(B), 32'(3'b100));
        applyStimulus(1'b0, 4'b0100, 1'b0, 2'd0, 1);
        checkOutput("C_after_rst", 32'(C), 32'(3'b001));
        applyStimulus(1'b0, 4'b0000, 1'b0, 2'd0, 10);

        // Random traffic with emergency episodes and occasional reset.
        ev = 1'b0;
        er = 2'd0;
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < 4; b++) q[b] = ($urandom_range(0, 7) == 0);
            if (!ev && $urandom_range(0, 59) == 0) begin
                ev = 1'b1;
                er = 2'($urandom_range(0, 3));
            end else if (ev && $urandom_range(0, 19) == 0) begin
                ev = 1'b0;
            end else if (ev && $urandom_range(0, 39) == 0) begin
                er = 2'($urandom_range(0, 3));
            end
            applyStimulus(($urandom_range(0, 399) == 0), q, ev, er, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
